// File: rtl/sopc_io_pkg.sv
// Shared definitions for the SOPC front-panel controller: register map and
// seven-segment encoding.
package sopc_io_pkg;

  localparam logic [2:0] REG_DISP = 3'd0;
  localparam logic [2:0] REG_CTRL = 3'd1;
  localparam logic [2:0] REG_LED  = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_EVT  = 3'd4;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter; a bit's
// debounced value follows its synced value only after DB_CYC stable cycles.
module io_debounce #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DB_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o
);

  localparam int unsigned CntW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYC - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  // Counter only runs while a change is pending; any bounce back restarts it.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/sopc_io_panel.sv
// Memory-mapped front-panel controller: seven-segment scan, button/switch
// debounce with sticky press events, and LED drive.
module sopc_io_panel
  import sopc_io_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned NUM_BTN     = 5,
  parameter int unsigned NUM_SW      = 8,
  parameter int unsigned NUM_LED     = 8,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic                  clk_100mhz,
  input  logic                  rst_n,
  input  logic                  io_ce,
  input  logic                  io_we,
  input  logic [2:0]            io_addr,
  input  logic [31:0]           io_wdata,
  output logic [31:0]           io_rdata,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic [NUM_SW-1:0]     sw,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [NUM_LED-1:0]    led
);

  localparam int unsigned SCAN_DIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned PreW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DigW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [DigW-1:0] DigMax = DigW'(NUM_DIGITS - 1);

  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_SW-1:0]  sw_db;

  io_debounce #(.WIDTH(NUM_BTN), .DB_CYC(DB_CYC)) u_btn_db (
    .clk_i (clk_100mhz),
    .rst_ni(rst_n),
    .raw_i (btn),
    .db_o  (btn_db)
  );

  io_debounce #(.WIDTH(NUM_SW), .DB_CYC(DB_CYC)) u_sw_db (
    .clk_i (clk_100mhz),
    .rst_ni(rst_n),
    .raw_i (sw),
    .db_o  (sw_db)
  );

  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, an_q, an_d;
  logic [NUM_LED-1:0]      led_q, led_d;
  logic [NUM_BTN-1:0]      evt_q, evt_d, btn_prev_q;
  logic [31:0]             rdata_q, rdata_d, rd_word;
  logic [PreW-1:0]         presc_q, presc_d;
  logic [DigW-1:0]         digit_q, digit_d;
  logic [7:0]              seg_q, seg_d;
  logic [DigW+1:0]         nib_idx;
  logic                    wrap;
  logic                    unused_wdata;

  assign unused_wdata = ^io_wdata;

  always_comb begin
    disp_d  = disp_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    led_d   = led_q;
    evt_d   = evt_q;
    if (io_ce && io_we) begin
      case (io_addr)
        REG_DISP: disp_d = io_wdata[4*NUM_DIGITS-1:0];
        REG_CTRL: begin
          dp_d    = io_wdata[NUM_DIGITS-1:0];
          blank_d = io_wdata[8 +: NUM_DIGITS];
        end
        REG_LED:  led_d = io_wdata[NUM_LED-1:0];
        REG_EVT:  evt_d = evt_q & ~io_wdata[NUM_BTN-1:0];
        default:  ;
      endcase
    end
    // A new press is OR-ed in after the clear so it is never lost.
    evt_d = evt_d | (btn_db & ~btn_prev_q);
  end

  always_comb begin
    rd_word = '0;
    case (io_addr)
      REG_DISP: rd_word[4*NUM_DIGITS-1:0] = disp_q;
      REG_CTRL: begin
        rd_word[NUM_DIGITS-1:0]    = dp_q;
        rd_word[8 +: NUM_DIGITS]   = blank_q;
      end
      REG_LED:  rd_word[NUM_LED-1:0] = led_q;
      REG_STAT: begin
        rd_word[NUM_BTN-1:0]     = btn_db;
        rd_word[16 +: NUM_SW]    = sw_db;
      end
      REG_EVT:  rd_word[NUM_BTN-1:0] = evt_q;
      default:  ;
    endcase
    rdata_d = (io_ce && !io_we) ? rd_word : rdata_q;
  end

  // an/seg latch the current digit at the wrap, then the index advances.
  always_comb begin
    wrap    = (presc_q == PreMax);
    presc_d = wrap ? '0 : presc_q + PreW'(1);
    digit_d = digit_q;
    an_d    = an_q;
    seg_d   = seg_q;
    nib_idx = {digit_q, 2'b00};
    if (wrap) begin
      digit_d = (digit_q == DigMax) ? '0 : digit_q + DigW'(1);
      an_d    = '1;
      if (!blank_q[digit_q]) begin
        an_d[digit_q] = 1'b0;
      end
      seg_d = {~dp_q[digit_q], hex_to_seg(disp_q[nib_idx +: 4])};
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      led_q      <= '0;
      evt_q      <= '0;
      btn_prev_q <= '0;
      rdata_q    <= '0;
      presc_q    <= '0;
      digit_q    <= '0;
      an_q       <= '1;
      seg_q      <= SEG_ALL_OFF;
    end else begin
      disp_q     <= disp_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      led_q      <= led_d;
      evt_q      <= evt_d;
      btn_prev_q <= btn_db;
      rdata_q    <= rdata_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign io_rdata = rdata_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign led      = led_q;

endmodule
